pcm_2_pdm: RTL and testbench
============================

PCM_2_PDM -- requirements
Module: pcm_2_pdm

Interface
REQ-001 SHALL have parameter PCM_W, default 16, PCM sample width (signed two's complement).
REQ-002 SHALL have parameter CLK_DIV, default 40, number of clk cycles per pdm_clk period (even, >= 4); 100 MHz / 40 = 2.5 MHz.
REQ-003 SHALL have parameter OSR, default 64, number of PDM bits per PCM sample (power of two, >= 8).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pcm_data, input, PCM_W, signed sample.
REQ-007 SHALL have port pcm_valid, input, 1, pcm_data valid.
REQ-008 SHALL have port pcm_ready, output, 1, holding register empty; sample accepted when pcm_valid and pcm_ready are both high on a clk edge.
REQ-009 SHALL have port pdm_clk, output, 1, PDM bit clock to the external filter/amplifier.
REQ-010 SHALL have port pdm_data, output, 1, PDM bitstream.
REQ-011 SHALL have port pdm_en, output, 1, amplifier enable (shutdown when low).
REQ-012 SHALL have port underrun, output, 1, one-clk pulse when a frame starts without a new sample.

Function
REQ-013 SHALL generate pdm_clk from a divider counter 0..CLK_DIV-1: pdm_clk low for counts 0..CLK_DIV/2-1, high for the rest; the bit tick is the cycle where the count wraps to 0 (pdm_clk falling edge).
REQ-014 SHALL update pdm_data only on the bit tick, so it is stable for a full half period before each pdm_clk rising edge.
REQ-015 SHALL keep a bit counter 0..OSR-1 advanced on each bit tick; a frame start is the bit tick on which the bit counter equals 0.
REQ-016 SHALL buffer samples in one holding register plus one current register; pcm_ready equals NOT holding-full.
REQ-017 At frame start with holding full, SHALL move holding to current and clear holding-full in the same cycle.
REQ-018 At frame start with holding empty and a simultaneous accept, SHALL load pcm_data directly into current, leave holding empty, and not pulse underrun.
REQ-019 At frame start with holding empty and no accept, SHALL reuse the current sample and pulse underrun for exactly one clk.
REQ-020 SHALL treat an accept in a cycle that is not a frame start as writing holding and setting holding-full; pcm_ready drops the next cycle.
REQ-021 First-order modulator (default): u = pcm with MSB inverted (unsigned offset, 0..2^PCM_W-1); on each bit tick acc(PCM_W+1 bits) <= acc[PCM_W-1:0] + u; pdm_data <= carry bit acc_next[PCM_W]; the 1s density equals u / 2^PCM_W exactly over 2^PCM_W ticks.
REQ-022 SHALL assert pdm_en on the first frame start that loads a sample and hold it high until reset; while pdm_en is low, pdm_data SHALL stay 0.
REQ-023 SHALL keep pdm_clk running whenever reset is deasserted, independent of pcm_valid.

Reset
REQ-024 While rst is low, SHALL force pdm_clk=0, pdm_data=0, pdm_en=0, underrun=0, pcm_ready=1; divider, bit counter, accumulator(s), current register and holding-full SHALL be cleared to 0.
REQ-025 Reset asserted mid-frame SHALL discard holding and current samples; after release the first bit tick occurs CLK_DIV clk cycles later.

Configuration
REQ-026 With macro PCM_2_PDM_SECOND_ORDER_EN defined, SHALL replace REQ-021 with a second-order modulator: signed integrators i1, i2 of PCM_W+4 bits; fb = +2^(PCM_W-1) if the previous pdm_data was 1, else -2^(PCM_W-1); per tick i1 <= i1 + pcm - fb, i2 <= i2 + i1_next - fb, pdm_data <= (i2_next >= 0).
REQ-027 Without PCM_2_PDM_SECOND_ORDER_EN, SHALL implement only the first-order modulator of REQ-021 with no second-order logic present.

Verification
REQ-028 Reset check: hold rst low 10 cycles -> pdm_clk=0, pdm_data=0, pdm_en=0, pcm_ready=1, underrun=0; release -> first pdm_clk rising edge at cycle 20, falling at 40 (defaults).
REQ-029 Mid-scale: stream pcm_data=16'h0000 continuously (first order) -> after the first frame pdm_data alternates 1,0,1,0 on successive bit ticks; pdm_en high.
REQ-030 Full-scale: pcm_data=16'h8000 -> pdm_data constant 0; pcm_data=16'h7FFF -> at most one 0 per 65536 bit ticks.
REQ-031 Underrun: feed one sample 16'h4000 then stop -> underrun pulses once per frame (every 64*40=2560 clk) and the 3/4 density is held; valid again -> pulses stop.
REQ-032 Handshake: pcm_valid held high -> exactly one accept per frame after the holding register fills, pcm_ready low between frames; accept coincident with frame start on empty holding -> no underrun pulse.
REQ-033 Second-order build: constant pcm_data=16'h2000 for 8192 bit ticks -> 1s density 0.625 +/- 0.005, integrators never overflow PCM_W+4 bits.

Source files
------------

// File: rtl/pcm_2_pdm.sv
// PCM-to-PDM converter: pdm_clk divider, holding/current sample buffer and delta-sigma modulator.
// Define PCM_2_PDM_SECOND_ORDER_EN to build a second-order modulator instead of the first-order one.
module pcm_2_pdm #(
    parameter int PCM_W   = 16,
    parameter int CLK_DIV = 40,
    parameter int OSR     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCM_W-1:0] pcm_data,
    input  logic             pcm_valid,
    output logic             pcm_ready,
    output logic             pdm_clk,
    output logic             pdm_data,
    output logic             pdm_en,
    output logic             underrun
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OSR_W = $clog2(OSR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [OSR_W-1:0] bit_cnt;
    logic             bit_tick;
    logic             frame_start;
    logic             accept;
    logic             load_now;
    logic             en_next;
    logic             hold_full;
    logic [PCM_W-1:0] hold_reg;
    logic [PCM_W-1:0] cur_reg;
    logic [PCM_W-1:0] sample_now;

    // The bit tick is the cycle on which the divider wraps, i.e. the pdm_clk falling edge.
    assign bit_tick    = (div_cnt == DIV_LAST);
    assign div_next    = bit_tick ? '0 : div_cnt + DIV_W'(1);
    assign frame_start = bit_tick && (bit_cnt == '0);
    assign pcm_ready   = !hold_full;
    assign accept      = pcm_valid && !hold_full;
    assign load_now    = frame_start && (hold_full || accept);
    assign en_next     = pdm_en || load_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= div_next;
            pdm_clk <= (div_next >= DIV_HALF);
            if (bit_tick)
                bit_cnt <= (bit_cnt == OSR_LAST) ? '0 : bit_cnt + OSR_W'(1);
        end
    end

    // Sample the modulator uses on this tick: a frame start may bring in a fresh sample.
    always_comb begin
        sample_now = cur_reg;
        if (frame_start) begin
            if (hold_full)
                sample_now = hold_reg;
            else if (accept)
                sample_now = pcm_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_reg  <= '0;
            cur_reg   <= '0;
            underrun  <= 1'b0;
            pdm_en    <= 1'b0;
        end else begin
            underrun <= frame_start && !hold_full && !accept;
            pdm_en   <= en_next;
            if (frame_start) begin
                cur_reg   <= sample_now;
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_reg  <= pcm_data;
                hold_full <= 1'b1;
            end
        end
    end

`ifdef PCM_2_PDM_SECOND_ORDER_EN
    localparam int INT_W = PCM_W + 4;
    localparam logic signed [INT_W-1:0] FB_POS = INT_W'(2 ** (PCM_W - 1));

    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;
    logic signed [INT_W-1:0] i1_next;
    logic signed [INT_W-1:0] i2_next;
    logic signed [INT_W-1:0] fb;
    logic signed [INT_W-1:0] pcm_ext;

    assign pcm_ext = {{4{sample_now[PCM_W-1]}}, sample_now};
    assign fb      = pdm_data ? FB_POS : -FB_POS;
    assign i1_next = i1 + pcm_ext - fb;
    assign i2_next = i2 + i1_next - fb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i1       <= '0;
            i2       <= '0;
            pdm_data <= 1'b0;
        end else if (bit_tick && en_next) begin
            i1       <= i1_next;
            i2       <= i2_next;
            pdm_data <= !i2_next[INT_W-1];
        end
    end
`else
    logic [PCM_W-1:0] acc;
    logic [PCM_W-1:0] u;
    logic [PCM_W:0]   acc_next;

    // Offset-binary sample; the accumulator carry is the output bit.
    assign u        = {~sample_now[PCM_W-1], sample_now[PCM_W-2:0]};
    assign acc_next = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            pdm_data <= 1'b0;
        end else if (bit_tick && en_next) begin
            acc      <= acc_next[PCM_W-1:0];
            pdm_data <= acc_next[PCM_W];
        end
    end
`endif

endmodule

// File: tb/tb_pcm_2_pdm.sv
// Scoreboard bench for pcm_2_pdm: a transaction-level model predicts every bit tick and underrun,
// and a monitor compares them against the DUT one time unit after each rising clk edge.
module tb_pcm_2_pdm;
    localparam int PCM_W   = 16;
    localparam int CLK_DIV = 8;
    localparam int OSR     = 16;
    localparam int FRAME   = CLK_DIV * OSR;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pcm_data = '0;
    logic        pcm_valid = 1'b0;
    logic        pcm_ready;
    logic        pdm_clk;
    logic        pdm_data;
    logic        pdm_en;
    logic        underrun;

    always #5 clk = ~clk;

    pcm_2_pdm #(.PCM_W(PCM_W), .CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_clk   (pdm_clk),
        .pdm_data  (pdm_data),
        .pdm_en    (pdm_en),
        .underrun  (underrun)
    );

    typedef struct {
        int   cyc;
        logic data;
        logic en;
    } tick_t;

    tick_t exp_ticks[$];
    int    exp_underrun[$];
    int    n_checks = 0;
    int    n_fail = 0;

    // Model state: cycle count since reset release, tick count, sample buffer and modulator
    int          cyc = 0;
    int          tick_count = 0;
    int          n_ticks_model = 0;
    int          n_ticks_seen = 0;
    logic        hold_valid = 1'b0;
    logic [15:0] hold_m = '0;
    logic [15:0] cur_m = '0;
    logic        en_m = 1'b0;
    logic        bit_m = 1'b0;
    longint      sum_m = 0;
    longint      ones_m = 0;
    longint      i1_m = 0;
    longint      i2_m = 0;
    longint      max_int = 0;
    logic        accept_m;
    logic        tick_m;
    logic        fs_m;
    logic        prev_clk = 1'b0;
    logic        dens_on = 1'b0;
    int          dens_ones = 0;
    int          dens_ticks = 0;

    task automatic check_output(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Next output bit from the density rule: emit a 1 whenever the running sum of offset samples
    // has crossed another multiple of 2^PCM_W (or the second-order difference equations).
    function automatic logic next_bit(input logic [15:0] s);
        longint v;
        longint fb;
        logic   b;
        v = longint'($signed(s));
`ifdef PCM_2_PDM_SECOND_ORDER_EN
        fb   = bit_m ? 32768 : -32768;
        i1_m = i1_m + v - fb;
        i2_m = i2_m + i1_m - fb;
        if ((i1_m < 0 ? -i1_m : i1_m) > max_int) max_int = (i1_m < 0 ? -i1_m : i1_m);
        if ((i2_m < 0 ? -i2_m : i2_m) > max_int) max_int = (i2_m < 0 ? -i2_m : i2_m);
        b = (i2_m >= 0);
`else
        fb    = 0;
        sum_m = sum_m + v + 32768 + fb;
        b     = ((sum_m / 65536) > ones_m);
        if (b) ones_m = ones_m + 1;
`endif
        return b;
    endfunction

    function automatic logic next_frame_start();
        return (((cyc + 1) % CLK_DIV) == 0) && ((tick_count % OSR) == 0);
    endfunction

    // Reference model: predicts the state each rising edge leaves behind
    always @(posedge clk) begin
        if (!rst) begin
            cyc = 0; tick_count = 0; hold_valid = 1'b0; hold_m = '0; cur_m = '0;
            en_m = 1'b0; bit_m = 1'b0; sum_m = 0; ones_m = 0; i1_m = 0; i2_m = 0;
        end else begin
            accept_m = pcm_valid && !hold_valid;
            cyc      = cyc + 1;
            tick_m   = ((cyc % CLK_DIV) == 0);
            fs_m     = tick_m && ((tick_count % OSR) == 0);
            if (fs_m) begin
                if (hold_valid) begin
                    cur_m = hold_m; hold_valid = 1'b0; en_m = 1'b1;
                end else if (accept_m) begin
                    cur_m = pcm_data; en_m = 1'b1;
                end else begin
                    exp_underrun.push_back(cyc);
                end
            end else if (accept_m) begin
                hold_m = pcm_data; hold_valid = 1'b1;
            end
            if (tick_m) begin
                tick_count = tick_count + 1;
                if (en_m) bit_m = next_bit(cur_m);
                exp_ticks.push_back('{cyc: cyc, data: bit_m, en: en_m});
                n_ticks_model++;
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge
    always @(posedge clk) begin
        tick_t t;
        int    u;
        #1;
        if (!rst) begin
            check_output("rst_pdm_clk", pdm_clk, 0);
            check_output("rst_pdm_data", pdm_data, 0);
            check_output("rst_pdm_en", pdm_en, 0);
            check_output("rst_underrun", underrun, 0);
            check_output("rst_pcm_ready", pcm_ready, 1);
            prev_clk = 1'b0;
        end else begin
            check_output("pcm_ready", pcm_ready, !hold_valid);
            check_output("pdm_clk", pdm_clk, ((cyc % CLK_DIV) >= CLK_DIV / 2));
            if (prev_clk && !pdm_clk) begin
                n_ticks_seen++;
                if (exp_ticks.size() == 0) begin
                    check_output("tick_unexpected", 1, 0);
                end else begin
                    t = exp_ticks.pop_front();
                    check_output("tick_cycle", cyc, t.cyc);
                    check_output("pdm_data", pdm_data, t.data);
                    check_output("pdm_en", pdm_en, t.en);
                    if (dens_on) begin
                        dens_ticks++;
                        if (pdm_data) dens_ones++;
                    end
                end
            end
            if (underrun) begin
                if (exp_underrun.size() == 0) begin
                    check_output("underrun_unexpected", 1, 0);
                end else begin
                    u = exp_underrun.pop_front();
                    check_output("underrun_cycle", cyc, u);
                end
            end
            prev_clk = pdm_clk;
        end
    end

    task automatic apply_stimulus(input logic v, input logic [15:0] d);
        @(negedge clk);
        pcm_valid = v;
        pcm_data  = d;
    endtask

    initial begin
        int guard;
        int pct;
        $display("[TB] start");
        repeat (10) @(negedge clk);
        rst = 1'b1;

        // Mid-scale stream: expected to settle into an alternating bit pattern
        for (int c = 0; c < 6 * FRAME; c++) apply_stimulus(1'b1, 16'h0000);

        // Random samples with per-frame valid density, plus one mid-frame reset
        for (int f = 0; f < 30; f++) begin
            pct = $urandom_range(5, 100);
            for (int c = 0; c < FRAME; c++) begin
                apply_stimulus(($urandom_range(1, 100) <= pct), 16'($urandom));
                if (f == 15 && c == FRAME / 2 + 3) begin
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (5) @(negedge clk);
                    rst = 1'b1;
                end
            end
        end

        // Accepts aligned with frame starts while holding is empty must not underrun
        for (int c = 0; c < 2 * FRAME; c++) apply_stimulus(1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            do begin
                apply_stimulus(1'b0, 16'h0000);
                guard++;
            end while (!next_frame_start() && guard < 3 * FRAME);
            check_output("frame_start_wait", (guard < 3 * FRAME), 1);
            pcm_valid = 1'b1;
            pcm_data  = 16'($urandom);
            apply_stimulus(1'b0, 16'h0000);
        end

        // Single sample then starvation: underrun every frame, sample reused
        for (int c = 0; c < FRAME; c++) apply_stimulus(1'b0, 16'h0000);
        apply_stimulus(1'b1, 16'h4000);
        for (int c = 0; c < 5 * FRAME; c++) apply_stimulus(1'b0, 16'h0000);
        for (int c = 0; c < 2 * FRAME; c++) apply_stimulus(1'b1, 16'h4000);

        // Full-scale negative and positive
        for (int c = 0; c < 4 * FRAME; c++) apply_stimulus(1'b1, 16'h8000);
        for (int c = 0; c < 4 * FRAME; c++) apply_stimulus(1'b1, 16'h7FFF);

`ifdef PCM_2_PDM_SECOND_ORDER_EN
        for (int c = 0; c < 2 * FRAME; c++) apply_stimulus(1'b1, 16'h2000);
        dens_on = 1'b1;
        for (int c = 0; c < 8192 * CLK_DIV; c++) apply_stimulus(1'b1, 16'h2000);
        dens_on = 1'b0;
        check_output("density_x1000_in_620_630",
                     ((dens_ones * 1000 >= 620 * dens_ticks) && (dens_ones * 1000 <= 630 * dens_ticks)), 1);
        check_output("integrators_in_range", (max_int < (longint'(1) << (PCM_W + 3))), 1);
`endif

        for (int c = 0; c < 2 * FRAME; c++) apply_stimulus(1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check_output("ticks_seen", n_ticks_seen, n_ticks_model);
        check_output("ticks_left", exp_ticks.size(), 0);
        check_output("underrun_left", exp_underrun.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
